// File: rtl/cpu_clock_pkg.sv
// Shared types and constants for the CPU clock-enable controller.
package cpu_clock_pkg;

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } clkState_e;

  localparam logic [1:0] MODE_STEP = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  // 20 ms of key stability at a 50 MHz clkIn
  localparam int unsigned DEBOUNCE_DEFAULT = 1000000;

  function automatic logic [1:0] modeOf(input clkState_e s);
    case (s)
      ST_RUN:  modeOf = MODE_RUN;
      ST_HALT: modeOf = MODE_HALT;
      default: modeOf = MODE_STEP;
    endcase
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Step-key synchronizer, debounce timer and press-event generator.
module key_debouncer
  import cpu_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clkIn,
  input  logic rstN,
  input  logic keyN,
  output logic press
);

  localparam logic [CNT_W-1:0] DB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       keySync;
  logic             keyS;
  logic             keyLevel;
  logic [CNT_W-1:0] dbCnt;

  assign keyS = keySync[1];

  // Two-flop synchronizer; resets to the released (high) level
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) keySync <= 2'b11;
    else       keySync <= {keySync[0], keyN};
  end

  // Down-counter reloads while the key matches the accepted level; reaching
  // zero with the key still different accepts the new level. A press is the
  // accepted level falling, flagged for exactly the cycle after acceptance.
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      dbCnt    <= '0;
      keyLevel <= 1'b1;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (keyS == keyLevel) begin
        dbCnt <= DB_LOAD;
      end else if (dbCnt == '0) begin
        keyLevel <= keyS;
        dbCnt    <= DB_LOAD;
        press    <= ~keyS;
      end else begin
        dbCnt <= dbCnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clock_control.sv
// CPU clock-enable controller: single-step from a debounced key, free-run
// from a divided slow clock, and halt on CPU request.
//
//   state | meaning
//   STEP  | one cpuEn pulse per debounced key press
//   RUN   | one cpuEn pulse per rising edge of slowClk
//   HALT  | no pulses; key press with runSw low returns to STEP
module cpu_clock_control
  import cpu_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clkIn,
  input  logic        rstN,
  input  logic        slowClk,
  input  logic        runSw,
  input  logic        stepKeyN,
  input  logic        haltReq,
  output logic        cpuEn,
  output logic [1:0]  mode,
  output logic [15:0] stepCount
);

  logic [1:0] slowSync;
  logic       slowPrev;
  logic [1:0] runSync;
  logic       tick;
  logic       runSwS;
  logic       press;
  logic       pulseNext;
  clkState_e  state;
  clkState_e  nextState;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) uKeyDebouncer (
    .clkIn(clkIn),
    .rstN (rstN),
    .keyN (stepKeyN),
    .press(press)
  );

  assign tick   = slowSync[1] & ~slowPrev;
  assign runSwS = runSync[1];
  assign mode   = modeOf(state);

  // Synchronize slowClk and runSw; slowPrev delays the synced slowClk for edge detect
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      slowSync <= 2'b00;
      slowPrev <= 1'b0;
      runSync  <= 2'b00;
    end else begin
      slowSync <= {slowSync[0], slowClk};
      slowPrev <= slowSync[1];
      runSync  <= {runSync[0], runSw};
    end
  end

  // State register
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) state <= ST_STEP;
    else       state <= nextState;
  end

  // Next-state logic; haltReq outranks every other input
  always_comb begin
    nextState = state;
    case (state)
      ST_STEP: begin
        if (haltReq)     nextState = ST_HALT;
        else if (runSwS) nextState = ST_RUN;
      end
      ST_RUN: begin
        if (haltReq)      nextState = ST_HALT;
        else if (!runSwS) nextState = ST_STEP;
      end
      ST_HALT: begin
        if (press && !runSwS) nextState = ST_STEP;
      end
      default: nextState = ST_STEP;
    endcase
  end

  // Pulse request for the next cycle; a concurrent haltReq swallows it
  always_comb begin
    pulseNext = 1'b0;
    case (state)
      ST_STEP: pulseNext = press && !haltReq;
      ST_RUN:  pulseNext = tick && !haltReq;
      default: pulseNext = 1'b0;
    endcase
  end

  // Registered enable pulse and the count of issued pulses
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      cpuEn     <= 1'b0;
      stepCount <= '0;
    end else begin
      cpuEn <= pulseNext;
      if (cpuEn) stepCount <= stepCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_clock_control.sv
// Directed bench for cpu_clock_control with a short debounce window.
module tb_cpu_clock_control;

  logic        clkIn;
  logic        rstN;
  logic        slowClk;
  logic        runSw;
  logic        stepKeyN;
  logic        haltReq;
  logic        cpuEn;
  logic [1:0]  mode;
  logic [15:0] stepCount;

  int nChecks;
  int nFails;
  int pulses;
  int firstIdx;

  cpu_clock_control #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .clkIn    (clkIn),
    .rstN     (rstN),
    .slowClk  (slowClk),
    .runSw    (runSw),
    .stepKeyN (stepKeyN),
    .haltReq  (haltReq),
    .cpuEn    (cpuEn),
    .mode     (mode),
    .stepCount(stepCount)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clkIn);
  endtask

  // Hold the key low for lowCycles, then watch cpuEn for monCycles negedges.
  // firstIdx is the negedge (counted from the press) of the first high sample.
  task automatic pressKey(input int lowCycles, input int monCycles,
                          output int nPulse, output int first);
    nPulse = 0;
    first  = -1;
    stepKeyN = 1'b0;
    for (int k = 1; k <= monCycles; k++) begin
      @(negedge clkIn);
      if (k == lowCycles) stepKeyN = 1'b1;
      if (cpuEn) begin
        nPulse++;
        if (first < 0) first = k;
      end
    end
  endtask

  // One slowClk period of 6 cycles; pulse and count update both land inside it
  task automatic oneTick();
    slowClk = 1'b1;
    cyc(2);
    slowClk = 1'b0;
    cyc(4);
  endtask

  initial begin
    nChecks  = 0;
    nFails   = 0;
    rstN     = 1'b0;
    runSw    = 1'b1;
    stepKeyN = 1'b0;
    haltReq  = 1'b1;
    slowClk  = 1'b0;

    // Reset held with every input active
    for (int i = 0; i < 12; i++) begin
      @(negedge clkIn);
      slowClk = ~slowClk;
      if (i % 4 == 3) begin
        checkEq("rst cpuEn", 32'(cpuEn), 32'd0);
        checkEq("rst mode", 32'(mode), 32'd0);
        checkEq("rst stepCount", 32'(stepCount), 32'd0);
      end
    end
    runSw    = 1'b0;
    stepKeyN = 1'b1;
    haltReq  = 1'b0;
    slowClk  = 1'b0;
    @(negedge clkIn);
    rstN = 1'b1;
    cyc(5);
    checkEq("step mode", 32'(mode), 32'd0);

    // Bounce shorter than the debounce window
    pressKey(3, 30, pulses, firstIdx);
    checkEq("short press pulses", 32'(pulses), 32'd0);
    checkEq("short press count", 32'(stepCount), 32'd0);

    // Real press: 2 sync + 8 debounce + 1 event edge -> pulse at negedge 11
    pressKey(20, 40, pulses, firstIdx);
    checkEq("long press pulses", 32'(pulses), 32'd1);
    checkEq("long press latency", 32'(firstIdx), 32'd11);
    checkEq("long press count", 32'(stepCount), 32'd1);

    // STEP ignores slowClk ticks
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      slowClk = ((i % 10) < 5);
      @(negedge clkIn);
      if (cpuEn) pulses++;
    end
    checkEq("step tick ignored", 32'(pulses), 32'd0);

    // RUN: 4 slowClk periods; pulse 3 edges after each rise, key press ignored
    runSw = 1'b1;
    cyc(4);
    checkEq("run mode", 32'(mode), 32'd1);
    for (int i = 0; i < 40; i++) begin
      slowClk  = ((i % 10) < 5);
      stepKeyN = (i >= 20);
      @(negedge clkIn);
      checkEq("run cpuEn", 32'(cpuEn), 32'(i % 10 == 2));
    end
    // one pulse from the STEP press plus four RUN ticks
    checkEq("run count", 32'(stepCount), 32'd5);
    checkEq("run mode after", 32'(mode), 32'd1);

    // haltReq coincident with a tick swallows the pulse
    for (int i = 0; i < 10; i++) begin
      slowClk = (i < 5);
      haltReq = (i == 2);
      @(negedge clkIn);
      checkEq("halt cpuEn", 32'(cpuEn), 32'd0);
    end
    haltReq = 1'b0;
    checkEq("halt mode", 32'(mode), 32'd2);

    // HALT ignores ticks, and a press while runSw is high
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      slowClk  = ((i % 10) < 5);
      stepKeyN = (i >= 20);
      @(negedge clkIn);
      if (cpuEn) pulses++;
    end
    checkEq("halt tick pulses", 32'(pulses), 32'd0);
    checkEq("halt hold mode", 32'(mode), 32'd2);
    checkEq("halt count", 32'(stepCount), 32'd5);

    // runSw low alone stays in HALT; a press then returns to STEP without a pulse
    runSw = 1'b0;
    cyc(4);
    checkEq("halt runSw0 mode", 32'(mode), 32'd2);
    pressKey(20, 40, pulses, firstIdx);
    checkEq("unhalt pulses", 32'(pulses), 32'd0);
    checkEq("unhalt mode", 32'(mode), 32'd0);
    checkEq("unhalt count", 32'(stepCount), 32'd5);

    // Wrap: preload the counter near the top rather than issuing 65536 ticks
    runSw = 1'b1;
    cyc(4);
    checkEq("wrap mode", 32'(mode), 32'd1);
    force dut.stepCount = 16'hFFFE;
    @(negedge clkIn);
    release dut.stepCount;
    oneTick();
    checkEq("wrap count ffff", 32'(stepCount), 32'h0000FFFF);
    oneTick();
    checkEq("wrap count 0000", 32'(stepCount), 32'h00000000);
    oneTick();
    checkEq("wrap count 0001", 32'(stepCount), 32'h00000001);

    // Reset during the cpuEn-high cycle
    slowClk = 1'b1;
    cyc(3);
    checkEq("pre-reset cpuEn", 32'(cpuEn), 32'd1);
    rstN = 1'b0;
    #1;
    checkEq("mid-pulse rst cpuEn", 32'(cpuEn), 32'd0);
    checkEq("mid-pulse rst mode", 32'(mode), 32'd0);
    checkEq("mid-pulse rst count", 32'(stepCount), 32'd0);
    slowClk = 1'b0;
    runSw   = 1'b0;
    cyc(3);
    rstN = 1'b1;
    cyc(3);

    // Reset during a debounce in progress
    stepKeyN = 1'b0;
    cyc(6);
    rstN     = 1'b0;
    stepKeyN = 1'b1;
    cyc(2);
    rstN = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clkIn);
      if (cpuEn) pulses++;
    end
    checkEq("post-reset pulses", 32'(pulses), 32'd0);
    checkEq("post-reset mode", 32'(mode), 32'd0);
    checkEq("post-reset count", 32'(stepCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/cpu_clock_control.md
CPU_CLOCK_CONTROL -- requirements
Module: cpu_clock_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000; clkIn cycles a key level must be stable before it is accepted (20 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 20; debounce counter width, at least ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-003 SHALL have port clkIn  input  1  system clock; the single clock.
REQ-004 SHALL have port rstN  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port slowClk  input  1  divided clock from the clock divider; treated as asynchronous.
REQ-006 SHALL have port runSw  input  1  mode switch: 1 = free-run, 0 = single-step; asynchronous.
REQ-007 SHALL have port stepKeyN  input  1  step push-button, active-low, bouncy, asynchronous.
REQ-008 SHALL have port haltReq  input  1  CPU halt request, synchronous to clkIn.
REQ-009 SHALL have port cpuEn  output  1  single-cycle CPU clock-enable pulse.
REQ-010 SHALL have port mode  output  2  state indication: 00 STEP, 01 RUN, 10 HALT.
REQ-011 SHALL have port stepCount  output  16  number of cpuEn pulses issued, wrapping.

Function
REQ-012 SHALL pass slowClk, runSw and stepKeyN through two-flop synchronizers before any use.
REQ-013 SHALL generate a one-cycle tick on each 0->1 transition of synchronized slowClk.
REQ-014 SHALL update the debounced key level only after the synchronized key holds a new value for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-015 SHALL generate a one-cycle press event on each 1->0 transition of the debounced key level.
REQ-016 SHALL implement FSM states STEP, RUN, HALT.
REQ-017 In STEP, press SHALL assert cpuEn on the next cycle; tick SHALL be ignored; runSw_s=1 SHALL move to RUN.
REQ-018 In RUN, tick SHALL assert cpuEn on the next cycle; press SHALL be ignored; runSw_s=0 SHALL move to STEP.
REQ-019 haltReq=1 in STEP or RUN SHALL move to HALT and suppress any cpuEn that tick or press would produce that cycle; haltReq has highest priority.
REQ-020 In HALT, cpuEn SHALL stay 0; press with runSw_s=0 SHALL move to STEP without a pulse; all other inputs SHALL be ignored.
REQ-021 cpuEn SHALL be registered, high for exactly one clkIn cycle per accepted event; slowClk rising to cpuEn high SHALL take exactly 3 clkIn edges.
REQ-022 stepCount SHALL increment by 1 in the cycle after each cpuEn pulse; 0xFFFF SHALL wrap to 0x0000.
REQ-023 mode SHALL reflect the registered FSM state.

Reset
REQ-024 rstN low SHALL immediately force cpuEn=0, mode=00 (STEP), stepCount=0, debounce counter=0.
REQ-025 Reset SHALL set the key synchronizer and the debounced level to 1 (released), and the slowClk and runSw synchronizers to 0.
REQ-026 Reset asserted mid-pulse or mid-debounce SHALL abort it; no pulse SHALL appear after release unless a new event occurs.

Structure
REQ-027 Package cpu_clock_pkg SHALL hold the state enumeration, the mode encodings and the DEBOUNCE_CYCLES default constant.
REQ-028 One sub-module, key_debouncer, SHALL contain the key synchronizer, debounce counter and press-event generator; all other logic SHALL stay in cpu_clock_control.

Verification (DEBOUNCE_CYCLES=8, CNT_W=4)
REQ-029 Drive rstN=0 with all inputs active -> cpuEn=0, mode=00, stepCount=0 throughout.
REQ-030 runSw=0; stepKeyN low 3 cycles then high -> no pulse; stepKeyN low 20 cycles -> exactly one cpuEn pulse, stepCount=1.
REQ-031 runSw=1; slowClk period 10 cycles for 4 periods -> mode=01, 4 single-cycle pulses each 3 edges after the slowClk rise, stepCount=4; key presses ignored.
REQ-032 RUN with haltReq coincident with tick -> no pulse, mode=10; further ticks -> no pulses; runSw=0 plus press -> mode=00, no pulse.
REQ-033 RUN for 65536 ticks -> stepCount returns to 0x0000.
REQ-034 rstN low during the cpuEn-high cycle -> cpuEn falls immediately; after release mode=00 and stepCount=0.
